// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// The CHK state only exists when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
`ifdef LOADER_CHECKSUM_EN
    , ST_CHK = 3'd3
`endif
  } state_e;

  localparam int LEN_ZERO_MEANS       = 256;
  localparam int DEFAULT_IDLE_TIMEOUT = 1023;

  // A length byte of zero encodes a full 256-byte image.
  function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
    return (len_byte == 8'd0) ? 9'(LEN_ZERO_MEANS) : {1'b0, len_byte};
  endfunction

endpackage

// File: rtl/program_loader.sv
// Byte-stream loader that fills the instruction memory while holding the CPU.
// Optional trailing checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader
  import loader_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'h00,
  parameter int         IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       done,
  output logic       error
);

  localparam int            TW      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(IDLE_TIMEOUT);

  function automatic logic is_busy(input state_e s);
    return (s == ST_LEN) || (s == ST_DATA)
`ifdef LOADER_CHECKSUM_EN
           || (s == ST_CHK)
`endif
           ;
  endfunction

  state_e        state_q, state_d, nxt_s;
  logic [8:0]    len_q, len_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          in_ready_q, in_ready_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          accept_s;
  logic          tmo_hit_s;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  // in_ready_q mirrors "state is LEN/DATA/CHK", so it doubles as the busy flag.
  assign accept_s  = in_valid & in_ready_q;
  assign tmo_hit_s = (IDLE_TIMEOUT > 0) && in_ready_q && (tmo_q == TMO_MAX);

  // Next-state, write-port and counter logic.
  always_comb begin
    nxt_s       = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    if (!in_ready_q || accept_s) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end else begin
      tmo_d = tmo_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          nxt_s = ST_LEN;
          len_d = 9'd0;
          cnt_d = 9'd0;
`ifdef LOADER_CHECKSUM_EN
          sum_d = 8'd0;
`endif
        end else begin
          nxt_s = state_q;
        end
      end
      ST_LEN: begin
        if (accept_s) begin
          len_d = decode_len(in_data);
          nxt_s = ST_DATA;
        end else begin
          nxt_s = ST_LEN;
        end
      end
      ST_DATA: begin
        if (accept_s) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + cnt_q[7:0];
          mem_wdata_d = in_data;
          cnt_d       = cnt_q + 9'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d       = sum_q + in_data;
          nxt_s       = (cnt_q == len_q - 9'd1) ? ST_CHK : ST_DATA;
`else
          nxt_s       = (cnt_q == len_q - 9'd1) ? ST_DONE : ST_DATA;
`endif
        end else begin
          nxt_s = ST_DATA;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          nxt_s = (in_data == sum_q) ? ST_DONE : ST_ERR;
        end else begin
          nxt_s = ST_CHK;
        end
      end
`endif
      default: nxt_s = ST_IDLE;
    endcase

    state_d    = tmo_hit_s ? ST_ERR : nxt_s;
    in_ready_d = is_busy(state_d);
    cpu_hold_d = is_busy(state_d) || (state_d == ST_ERR);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  // State and registered outputs; reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= 9'd0;
      cnt_q       <= 9'd0;
      tmo_q       <= {TW{1'b0}};
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 8'd0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'h00: first instruction-memory address written.
REQ-002 SHALL have parameter IDLE_TIMEOUT, default 1023: max cycles without in_valid while loading before error; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle load request.
REQ-006 SHALL have port in_data  input  8  incoming byte.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-009 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port mem_addr  output  8  write address.
REQ-011 SHALL have port mem_wdata  output  8  8-bit instruction to write.
REQ-012 SHALL have port cpu_hold  output  1  keeps CPU/PC stalled while high.
REQ-013 SHALL have port done  output  1  load completed successfully (level).
REQ-014 SHALL have port error  output  1  load failed (level).

Function
REQ-015 SHALL implement states IDLE, LEN, DATA, CHK, DONE, ERR.
REQ-016 Byte acceptance SHALL occur only on a cycle with in_valid and in_ready both high; in_ready SHALL be high exactly in LEN, DATA, CHK.
REQ-017 start SHALL move IDLE, DONE or ERR to LEN, clear done/error, raise cpu_hold next cycle; start in LEN/DATA/CHK SHALL be ignored.
REQ-018 In LEN the accepted byte SHALL be length N, value 0 meaning 256; go to DATA.
REQ-019 In DATA the k-th accepted byte (k=0..N-1) SHALL produce, the following cycle, a one-cycle mem_we with mem_addr = (BASE_ADDR+k) mod 256 and mem_wdata = byte; address SHALL wrap 255->0.
REQ-020 After the N-th data byte is accepted, next state SHALL be CHK if checksum compiled in, else DONE.
REQ-021 DONE: done=1, cpu_hold=0, held until start or reset.
REQ-022 ERR: error=1, cpu_hold=1 (CPU stays stalled), held until start or reset.
REQ-023 With IDLE_TIMEOUT>0, a counter SHALL count consecutive LEN/DATA/CHK cycles with in_valid low, reset on any accepted byte; reaching IDLE_TIMEOUT SHALL go to ERR next cycle.
REQ-024 mem_addr/mem_wdata SHALL hold last values when mem_we is low.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, done=0, error=0, counters and checksum=0.
REQ-026 Reset mid-load SHALL abandon the load with no further mem_we; already-written words remain.

Configuration
REQ-027 Macro LOADER_CHECKSUM_EN defined: CHK state exists; the accepted byte is compared with 8-bit mod-256 sum of the N data bytes; equal -> DONE, unequal -> ERR.
REQ-028 LOADER_CHECKSUM_EN undefined: no CHK state, no sum register, DATA goes directly to DONE.

Structure
REQ-029 Package loader_pkg SHALL hold the state enum typedef and constants LEN_ZERO_MEANS (256) and the default IDLE_TIMEOUT.
REQ-030 No sub-module: single FSM with address, byte and timeout counters; connects to a writable variant of the 256x8 instruction memory.

Verification
REQ-031 start, bytes 03,A1,B2,C3 (valid every cycle), BASE_ADDR=0 -> writes 00:A1,01:B2,02:C3; done=1; cpu_hold low after.
REQ-032 Checksum on: 02,10,20,30 -> DONE; 02,10,20,31 -> ERR, error=1, cpu_hold=1.
REQ-033 BASE_ADDR=8'hFE, length 03 -> writes to FE, FF, 00.
REQ-034 Length 00 -> exactly 256 writes, addresses 00..FF, then DONE.
REQ-035 IDLE_TIMEOUT=4, in_valid dropped after 1 data byte -> ERR 5 cycles later; in_valid gaps of 3 cycles -> no error.
REQ-036 rst_n low after 2nd data byte -> all outputs reset same cycle, no further mem_we; fresh start reloads normally.
